// File: rtl/ppr_quad_gen.sv
// Incremental-encoder emulator: quadrature A/B plus index Z for a selectable PPR.
// PPR changes are deferred to a revolution boundary, or applied at once while stopped.
module ppr_quad_gen #(
  parameter int         CNT_W       = 10,
  parameter int         DIV_W       = 16,
  parameter int         REV_W       = 16,
  parameter logic [3:0] DEFAULT_SEL = 4'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic [3:0]       pr_sel,
  input  logic [DIV_W-1:0] step_div,
  output logic             quad_a,
  output logic             quad_b,
  output logic             index_z,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] ppr_act,
  output logic             sel_pending,
  output logic             rev_pulse,
  output logic [REV_W-1:0] rev_cnt
);

  function automatic logic [CNT_W-1:0] ppr_lut(input logic [3:0] sel);
    logic [9:0] v;
    case (sel)
      4'd0:    v = 10'd63;
      4'd1:    v = 10'd99;
      4'd2:    v = 10'd127;
      4'd3:    v = 10'd199;
      4'd4:    v = 10'd255;
      4'd5:    v = 10'd299;
      4'd6:    v = 10'd359;
      4'd7:    v = 10'd399;
      4'd8:    v = 10'd499;
      4'd9:    v = 10'd599;
      4'd10:   v = 10'd699;
      4'd11:   v = 10'd719;
      4'd12:   v = 10'd799;
      4'd13:   v = 10'd899;
      4'd14:   v = 10'd999;
      default: v = 10'd1023;
    endcase
    return CNT_W'(v);
  endfunction

  // phase 0..3 maps to {A,B} = 00,01,11,10; forward counts up
  logic [1:0]       phase, phase_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [CNT_W-1:0] line_nxt, ppr_nxt, ppr_req, ppr_wrap;
  logic [REV_W-1:0] rev_nxt;
  logic             pulse_nxt, step;

  always_comb begin
    ppr_req   = ppr_lut(pr_sel);
    ppr_wrap  = sel_pending ? ppr_req : ppr_act;
    step      = en && (div_cnt >= step_div);
    phase_nxt = phase;
    div_nxt   = div_cnt;
    line_nxt  = line_cnt;
    ppr_nxt   = ppr_act;
    rev_nxt   = rev_cnt;
    pulse_nxt = 1'b0;
    if (!en) begin
      div_nxt = '0;
      if (sel_pending) begin
        ppr_nxt   = ppr_req;
        line_nxt  = '0;
        phase_nxt = 2'd0;
      end
    end else if (step) begin
      div_nxt = '0;
      if (!dir) begin
        phase_nxt = phase + 2'd1;
        if (phase == 2'd3) begin
          if (line_cnt == ppr_act) begin
            line_nxt  = '0;
            ppr_nxt   = ppr_wrap;
            rev_nxt   = rev_cnt + REV_W'(1);
            pulse_nxt = 1'b1;
          end else begin
            line_nxt = line_cnt + CNT_W'(1);
          end
        end
      end else begin
        phase_nxt = phase - 2'd1;
        if (phase == 2'd0) begin
          // reverse wrap lands on the last line of the (possibly new) table entry
          if (line_cnt == '0) begin
            ppr_nxt   = ppr_wrap;
            line_nxt  = ppr_wrap;
            rev_nxt   = rev_cnt - REV_W'(1);
            pulse_nxt = 1'b1;
          end else begin
            line_nxt = line_cnt - CNT_W'(1);
          end
        end
      end
    end else begin
      div_nxt = div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= 2'd0;
      div_cnt     <= '0;
      line_cnt    <= '0;
      ppr_act     <= ppr_lut(DEFAULT_SEL);
      rev_cnt     <= '0;
      sel_pending <= 1'b0;
      rev_pulse   <= 1'b0;
      quad_a      <= 1'b0;
      quad_b      <= 1'b0;
      index_z     <= 1'b1;
    end else begin
      phase       <= phase_nxt;
      div_cnt     <= div_nxt;
      line_cnt    <= line_nxt;
      ppr_act     <= ppr_nxt;
      rev_cnt     <= rev_nxt;
      sel_pending <= (ppr_req != ppr_act);
      rev_pulse   <= pulse_nxt;
      quad_a      <= phase_nxt[1];
      quad_b      <= phase_nxt[1] ^ phase_nxt[0];
      index_z     <= (line_nxt == '0) && (phase_nxt == 2'd0);
    end
  end

endmodule

// File: tb/tb_ppr_quad_gen.sv
// Randomised and directed bench for ppr_quad_gen against a position-count model
// (quadrature count within the revolution, not line/phase registers).
module tb_ppr_quad_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        dir = 1'b0;
  logic [3:0]  pr_sel = 4'd0;
  logic [15:0] step_div = 16'd0;
  logic        quad_a, quad_b, index_z, sel_pending, rev_pulse;
  logic [9:0]  line_cnt, ppr_act;
  logic [15:0] rev_cnt;

  ppr_quad_gen dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .pr_sel(pr_sel), .step_div(step_div),
    .quad_a(quad_a), .quad_b(quad_b), .index_z(index_z), .line_cnt(line_cnt),
    .ppr_act(ppr_act), .sel_pending(sel_pending), .rev_pulse(rev_pulse), .rev_cnt(rev_cnt)
  );

  always #5 clk = ~clk;

  logic [40:0] obs;
  assign obs = {quad_a, quad_b, index_z, line_cnt, ppr_act, sel_pending, rev_pulse, rev_cnt};

  int n_checks = 0;
  int n_err = 0;

  int TBL [16] = '{63, 99, 127, 199, 255, 299, 359, 399, 499, 599, 699, 719, 799, 899, 999, 1023};
  int GRAY[4]  = '{0, 1, 3, 2};

  // model: m_q counts quadrature states since line 0 phase 0
  int m_q, m_ppr, m_rev, m_div;
  bit m_pend, m_pulse;

  function automatic logic [40:0] exp_v();
    logic [1:0]  ab;
    logic [9:0]  ln, pp;
    logic [15:0] rv;
    ab = 2'(GRAY[m_q % 4]);
    ln = 10'(m_q / 4);
    pp = 10'(m_ppr);
    rv = 16'(m_rev);
    return {ab, (m_q == 0), ln, pp, m_pend, m_pulse, rv};
  endfunction

  task automatic model_reset();
    m_q = 0; m_ppr = TBL[0]; m_rev = 0; m_div = 0; m_pend = 0; m_pulse = 0;
  endtask

  task automatic model_edge();
    int req;
    bit np;
    req = TBL[pr_sel];
    np = (req != m_ppr);
    m_pulse = 0;
    if (!en) begin
      m_div = 0;
      if (m_pend) begin
        m_ppr = req;
        m_q = 0;
      end
    end else if (m_div >= int'(step_div)) begin
      m_div = 0;
      if (!dir) begin
        m_q++;
        if (m_q == 4 * (m_ppr + 1)) begin
          m_q = 0;
          m_rev = (m_rev + 1) % 65536;
          m_pulse = 1;
          if (m_pend) m_ppr = req;
        end
      end else if (m_q == 0) begin
        if (m_pend) m_ppr = req;
        m_q = 4 * (m_ppr + 1) - 1;
        m_rev = (m_rev + 65535) % 65536;
        m_pulse = 1;
      end else begin
        m_q--;
      end
    end else begin
      m_div++;
    end
    m_pend = np;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pr_sel = 4'd0; en = 1'b1; dir = 1'b0; step_div = 16'd3;
    reset = 1'b1;
    #2;
    model_reset();
    n_checks++;
    if (obs !== 41'h03_0003F_0000 >> 0 && obs !== exp_v()) begin
      n_err++; $display("FAIL reset_state got=%h exp=%h", obs, exp_v());
    end
    n_checks++;
    if ({quad_a, quad_b, index_z, line_cnt, ppr_act, rev_cnt} !== {3'b001, 10'd0, 10'd63, 16'd0}) begin
      n_err++; $display("FAIL reset_const got=%b%b%b %0d %0d %0d exp=001 0 63 0",
                        quad_a, quad_b, index_z, line_cnt, ppr_act, rev_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_forward_rev();
    int pulses;
    pulses = 0;
    for (int i = 1; i <= 1030; i++) begin
      tick();
      pulses += int'(rev_pulse);
      n_checks++;
      if (obs !== exp_v()) begin
        n_err++; $display("FAIL fwd_rev cyc=%0d got=%h exp=%h", i, obs, exp_v());
      end
      if (i == 1024) begin
        n_checks++;
        if ({rev_pulse, rev_cnt, line_cnt, index_z} !== {1'b1, 16'd1, 10'd0, 1'b1}) begin
          n_err++; $display("FAIL fwd_wrap pulse=%b rev=%0d line=%0d z=%b exp=1 1 0 1",
                            rev_pulse, rev_cnt, line_cnt, index_z);
        end
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL fwd_pulse_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_switch_fwd();
    int t, wrap_at;
    do_reset();
    pr_sel = 4'd0; en = 1'b1; dir = 1'b0; step_div = 16'd0;
    t = 0;
    while (m_q != 40 && t < 200) begin tick(); t++; end
    pr_sel = 4'd4;
    t = 0;
    while (!m_pulse && t < 400) begin
      tick(); t++;
      n_checks++;
      if (obs !== exp_v()) begin
        n_err++; $display("FAIL switch_run cyc=%0d got=%h exp=%h", t, obs, exp_v());
      end
    end
    n_checks++;
    if ({ppr_act, rev_pulse, line_cnt} !== {10'd255, 1'b1, 10'd0}) begin
      n_err++; $display("FAIL switch_apply ppr=%0d pulse=%b line=%0d exp=255 1 0", ppr_act, rev_pulse, line_cnt);
    end
    wrap_at = 0;
    for (int i = 1; i <= 1030; i++) begin
      tick();
      if (rev_pulse && wrap_at == 0) wrap_at = i;
      n_checks++;
      if (obs !== exp_v()) begin
        n_err++; $display("FAIL switch_rev2 cyc=%0d got=%h exp=%h", i, obs, exp_v());
      end
    end
    n_checks++;
    if (wrap_at !== 1024) begin
      n_err++; $display("FAIL switch_span got=%0d exp=1024", wrap_at);
    end
  endtask

  task automatic test_reverse_start();
    do_reset();
    pr_sel = 4'd0; en = 1'b1; dir = 1'b1; step_div = 16'd0;
    tick();
    n_checks++;
    if ({quad_a, quad_b, line_cnt, rev_cnt, rev_pulse} !== {2'b10, 10'd63, 16'hFFFF, 1'b1}) begin
      n_err++; $display("FAIL rev_first ab=%b%b line=%0d rev=%h pulse=%b exp=10 63 ffff 1",
                        quad_a, quad_b, line_cnt, rev_cnt, rev_pulse);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_v()) begin
        n_err++; $display("FAIL rev_run cyc=%0d got=%h exp=%h", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_stop_switch();
    int t;
    do_reset();
    pr_sel = 4'd0; en = 1'b1; dir = 1'b0; step_div = 16'd0;
    for (int i = 0; i < 70; i++) tick();
    pr_sel = 4'd15;
    t = 0;
    while (m_q != 82 && t < 50) begin tick(); t++; end
    n_checks++;
    if ({line_cnt, quad_a, quad_b, sel_pending} !== {10'd20, 2'b11, 1'b1}) begin
      n_err++; $display("FAIL stop_pre line=%0d ab=%b%b pend=%b exp=20 11 1", line_cnt, quad_a, quad_b, sel_pending);
    end
    en = 1'b0;
    tick();
    n_checks++;
    if ({ppr_act, line_cnt, quad_a, quad_b, index_z, sel_pending} !== {10'd1023, 10'd0, 2'b00, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL stop_apply ppr=%0d line=%0d ab=%b%b z=%b pend=%b exp=1023 0 00 1 1",
                        ppr_act, line_cnt, quad_a, quad_b, index_z, sel_pending);
    end
    tick();
    n_checks++;
    if (sel_pending !== 1'b0 || obs !== exp_v()) begin
      n_err++; $display("FAIL stop_pend_clear got=%h exp=%h", obs, exp_v());
    end
  endtask

  task automatic test_prescaler();
    logic [1:0] prev;
    do_reset();
    pr_sel = 4'd0; en = 1'b1; dir = 1'b0; step_div = 16'd100;
    for (int i = 0; i < 50; i++) tick();
    n_checks++;
    if ({quad_a, quad_b} !== 2'b00) begin
      n_err++; $display("FAIL presc_hold ab=%b%b exp=00", quad_a, quad_b);
    end
    step_div = 16'd10;
    tick();
    n_checks++;
    if ({quad_a, quad_b} !== 2'b01) begin
      n_err++; $display("FAIL presc_lower ab=%b%b exp=01", quad_a, quad_b);
    end
    for (int k = 1; k <= 22; k++) begin
      prev = {quad_a, quad_b};
      tick();
      n_checks++;
      if ((({quad_a, quad_b} != prev) !== ((k % 11) == 0)) || obs !== exp_v()) begin
        n_err++; $display("FAIL presc_period k=%0d got=%h exp=%h", k, obs, exp_v());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1; dir = 1'b0; pr_sel = 4'd0; step_div = 16'd0;
    for (int i = 1; i <= 4000; i++) begin
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 49) == 0) pr_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) step_div = 16'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) != 0);
      tick();
      n_checks++;
      if (obs !== exp_v()) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; dir = 1'b0; pr_sel = 4'd0; step_div = 16'd0;
    for (int i = 0; i < 30; i++) tick();
    pr_sel = 4'd9;
    tick(); tick();
    n_checks++;
    if (sel_pending !== 1'b1) begin
      n_err++; $display("FAIL async_pre pend=%b exp=1", sel_pending);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs !== exp_v() || ppr_act !== 10'd63) begin
      n_err++; $display("FAIL async_reset got=%h exp=%h", obs, exp_v());
    end
    reset = 1'b0;
    pr_sel = 4'd0;
    tick();
    n_checks++;
    if (obs !== exp_v()) begin
      n_err++; $display("FAIL async_after got=%h exp=%h", obs, exp_v());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_forward_rev();
    test_switch_fwd();
    test_reverse_start();
    test_stop_switch();
    test_prescaler();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
